paicore_recv_2c: RTL

Receive-side counterpart of the two-core send path. Accepts 32-bit words from two PAICORE output channels over 4-phase request/acknowledge handshakes and packs pairs of words into 64-bit beats per channel. Merges both channels round-robin onto one AXI-Stream master toward the DMA, asserting tlast and a done pulse after a programmed beat count. Sits between the chip output pins and the DMA S2MM stream.

---
 rtl/paicore_rx_pkg.sv | 15 +
 rtl/paicore_recv_2c_if.sv | 16 +
 rtl/paicore_rx_chan.sv | 100 ++++++++++
 rtl/paicore_recv_2c.sv | 107 ++++++++++
 4 files changed

// File: rtl/paicore_rx_pkg.sv
// Shared constants for the two-core receive path.
// Holds the data widths, the per-channel handshake FSM encoding and the
// channel indices used by the round-robin merge.
package paicore_rx_pkg;
    localparam int WORD_W = 32;
    localparam int BEAT_W = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } chan_state_e;

    localparam logic C0 = 1'b0;
    localparam logic C1 = 1'b1;
endpackage

// File: rtl/paicore_recv_2c_if.sv
// AXI-Stream bundle from the receive path toward the DMA S2MM port.
//   master: drives m_axis_tdata/tlast/tvalid, samples m_axis_tready
//   slave : the opposite view (DMA side / testbench)
interface paicore_recv_2c_if;
    import paicore_rx_pkg::*;

    logic [BEAT_W-1:0] m_axis_tdata;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;

    modport master (output m_axis_tdata, m_axis_tlast, m_axis_tvalid,
                    input  m_axis_tready);
    modport slave  (input  m_axis_tdata, m_axis_tlast, m_axis_tvalid,
                    output m_axis_tready);
endinterface

// File: rtl/paicore_rx_chan.sv
// One receive channel: request synchronizer, 4-phase handshake FSM,
// half-word packer and beat FIFO.
//   clk, rst    : clock, async active-high reset
//   clear       : drop FIFO contents and any half word (transfer restart)
//   en          : new captures allowed (rx_enable & armed)
//   request/din : asynchronous core request and its bundled data
//   ack         : core acknowledge
//   pop/dout/empty : FIFO read side, dout is the head entry
module paicore_rx_chan
    import paicore_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic              request,
    input  logic [WORD_W-1:0] din,
    output logic              ack,
    input  logic              pop,
    output logic [BEAT_W-1:0] dout,
    output logic              empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] sync;
    logic                   req_s;
    chan_state_e            state, state_nxt;
    logic                   cap, push, full, slot_ok;
    logic [WORD_W-1:0]      half;
    logic                   half_vld;
    logic [BEAT_W-1:0]      mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], request};
    end
    assign req_s = sync[SYNC_STAGES-1];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    // A word can land either in the empty half register or, completing a
    // beat, in a free FIFO slot.
    assign slot_ok = !full || !half_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // A capture colliding with clear is skipped; the request stays high so
    // the word is taken on a later cycle into the fresh transfer.
    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        case (state)
            ST_IDLE: if (req_s && en && slot_ok && !clear) begin
                cap       = 1'b1;
                state_nxt = ST_ACK;
            end
            ST_ACK:  if (!req_s) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ack  = (state == ST_ACK);
    assign push = cap && half_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half     <= '0;
            half_vld <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (clear) begin
            half_vld <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (cap) begin
                if (half_vld) half_vld <= 1'b0;
                else begin
                    half     <= din;
                    half_vld <= 1'b1;
                end
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {din, half};
    end

    assign dout = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/paicore_recv_2c.sv
// Two-core receive path: two handshake channels packed into 64-bit beats,
// merged round-robin onto one AXI-Stream master with a programmed length.
//   clk, rst           : clock, async active-high reset
//   rx_enable          : gate for starting new core handshakes
//   rx_start, recv_len : arm a transfer of recv_len beats (0 = unbounded)
//   beat_cnt           : beats accepted downstream since rx_start
//   axis               : AXI-Stream master toward the DMA
//   request/din/acknowledge_Cx : 4-phase core output channels
//   o_rx_done          : one-cycle pulse after the tlast beat is accepted
module paicore_recv_2c
    import paicore_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_enable,
    input  logic                 rx_start,
    input  logic [31:0]          recv_len,
    output logic [31:0]          beat_cnt,
    paicore_recv_2c_if.master    axis,
    input  logic                 request_C0,
    input  logic [WORD_W-1:0]    din_C0,
    output logic                 acknowledge_C0,
    input  logic                 request_C1,
    input  logic [WORD_W-1:0]    din_C1,
    output logic                 acknowledge_C1,
    output logic                 o_rx_done
);
    logic                    armed, rr, sel, hs, last_hs, load;
    logic [31:0]             len_q, cnt_nxt;
    logic [1:0]              req_v, ack_v, pop, empty;
    logic [1:0][WORD_W-1:0]  din_v;
    logic [1:0][BEAT_W-1:0]  dout;

    assign req_v = {request_C1, request_C0};
    assign din_v = {din_C1, din_C0};
    assign acknowledge_C0 = ack_v[0];
    assign acknowledge_C1 = ack_v[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        paicore_rx_chan #(.SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .clear   (rx_start),
            .en      (rx_enable && armed),
            .request (req_v[gi]),
            .din     (din_v[gi]),
            .ack     (ack_v[gi]),
            .pop     (pop[gi]),
            .dout    (dout[gi]),
            .empty   (empty[gi])
        );
    end

    // rr is the preferred channel; a lone non-empty FIFO is served directly.
    always_comb begin
        sel = rr;
        if (empty[C0])      sel = C1;
        else if (empty[C1]) sel = C0;
    end

    assign hs      = axis.m_axis_tvalid && axis.m_axis_tready;
    assign last_hs = hs && axis.m_axis_tlast;
    assign cnt_nxt = beat_cnt + {31'd0, hs};
    // Refill when the output slot is free or emptying this cycle. Nothing is
    // loaded behind the tlast beat or while unarmed.
    assign load = (!axis.m_axis_tvalid || axis.m_axis_tready) && !(&empty)
                  && armed && !last_hs && !rx_start;
    assign pop  = load ? ((sel == C1) ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axis.m_axis_tdata  <= '0;
            axis.m_axis_tlast  <= 1'b0;
            axis.m_axis_tvalid <= 1'b0;
            beat_cnt  <= '0;
            len_q     <= '0;
            armed     <= 1'b0;
            rr        <= C0;
            o_rx_done <= 1'b0;
        end else if (rx_start) begin
            axis.m_axis_tdata  <= '0;
            axis.m_axis_tlast  <= 1'b0;
            axis.m_axis_tvalid <= 1'b0;
            beat_cnt  <= '0;
            len_q     <= recv_len;
            armed     <= 1'b1;
            rr        <= C0;
            o_rx_done <= 1'b0;
        end else begin
            o_rx_done <= last_hs;
            if (last_hs) armed <= 1'b0;
            beat_cnt <= cnt_nxt;
            if (load) begin
                axis.m_axis_tvalid <= 1'b1;
                axis.m_axis_tdata  <= dout[sel];
                // Index of the beat being loaded is the post-handshake count.
                axis.m_axis_tlast  <= (len_q != 32'd0) && (cnt_nxt == len_q - 32'd1);
                rr <= ~sel;
            end else if (hs) begin
                axis.m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule
